fantasticfft_fft8_drain: RTL
============================

# fantasticfft_fft8_drain

Output-side companion to the 8-point FFT core. It captures one complete FFT8 result frame (eight complex Q8.8 bins) on the core's result-valid strobe and buffers up to two frames. It streams the bins out one per cycle over a valid/ready handshake, with a per-bin L1 magnitude. It sits between the FFT8 core outputs and any serial consumer (spectrum memory writer, UART dumper, peak detector), so the parallel core can run without back-pressure logic.

## Interface
- WIDTH, 16, total bits per real/imag sample (signed fixed point)
- FRAC, 8, fractional bits (Q8.8 by default); carried through unchanged
- BITREV, 0, 0 = emit bins 0..7 in natural order; 1 = emit in bit-reversed order 0,4,2,6,1,5,3,7
- clk  input  1  clock; all state on rising edge
- rst  input  1  asynchronous, active-high reset
- fft_valid  input  1  one-cycle strobe: y_re/y_im hold a new frame
- y_re  input  8*WIDTH  real parts, bin k at [WIDTH*k +: WIDTH]
- y_im  input  8*WIDTH  imaginary parts, same packing
- in_ready  output  1  a frame slot is free (from registered occupancy)
- out_valid  output  1  out_* holds a valid bin
- out_ready  input  1  consumer accepts the bin this cycle
- out_re / out_im  output  WIDTH each  current bin value
- out_mag  output  WIDTH+1  unsigned |re|+|im|, same FRAC
- out_bin  output  3  natural index of the current bin
- out_last  output  1  current bin is the frame's final emitted bin
- clr_ovf  input  1  synchronous clear of overrun and drop_cnt
- overrun  output  1  sticky: a frame was dropped
- drop_cnt  output  8  saturating count of dropped frames

## Operation
- Storage: two frame slots (ping-pong), write pointer, read pointer, 2-bit occupancy count (0..2), 3-bit emit counter.
- Capture: on rising edge with fft_valid=1 and count<2, all 16 samples are written to the write slot, the write pointer toggles, and count increments.
- Drop: fft_valid=1 while count==2 means the frame is discarded. overrun is set and drop_cnt increments, saturating at 255. Slot contents are untouched.
- in_ready = (count<2), purely from registered count. A last-bin handshake in the same cycle does not free a slot for that cycle's fft_valid.
- FSM states:
  - IDLE: count==0, out_valid=0.
  - STREAM: count>0, out_valid=1.
  - IDLE→STREAM on capture.
  - STREAM→IDLE when the last bin handshakes and no other frame is buffered and no capture occurs that cycle.
- Emit order: the emit counter e runs 0..7 and advances only on out_valid&&out_ready. out_bin = e (BITREV=0) or bitrev3(e) (BITREV=1). out_last = (e==7).
- On the last-bin handshake: e returns to 0, the read pointer toggles, and count decrements. Simultaneous capture and release leaves count unchanged.
- out_mag: abs of each component in WIDTH+1 bits, summed and truncated to WIDTH+1. abs(-2^(WIDTH-1)) = 2^(WIDTH-1) is exact. There is no saturation; full scale is 2^WIDTH, which fits.
- clr_ovf: clears overrun and drop_cnt. A drop in the same cycle wins: overrun=1, drop_cnt=1.

## Timing
- Reset values:
  - out_valid=0, out_re=0, out_im=0, out_mag=0, out_bin=0, out_last=0
  - overrun=0, drop_cnt=0, in_ready=1
  - count=0, pointers=0, e=0, state IDLE
- Reset mid-stream aborts the frame and discards both slots immediately.
- Latency: a frame captured at edge N presents bin 0 with out_valid=1 after edge N, so it is usable at edge N+1.
- Outputs are registered. All out_* stay stable while out_valid=1 and out_ready=0.
- Throughput: one bin per cycle with out_ready held high. Consecutive buffered frames stream back-to-back with no bubble: bin 0 of the next frame follows the out_last handshake directly.
- fft_valid held high for multiple cycles counts as one frame per cycle.

## Test plan
- Ramp frame (FFT of 1..8): y0=0x2400+j0, y2=0xFC00+j0x0400, y4=0xFC00+j0, y6=0xFC00+j0xFC00, out_ready=1 → bins 0..7 on 8 consecutive cycles starting the cycle after capture. out_mag for bin0=0x02400, bin2=0x00800, bin4=0x00400. out_last only on bin 7.
- BITREV=1, same frame → out_bin sequence 0,4,2,6,1,5,3,7 with matching data.
- Back-pressure: toggle out_ready 1,0,0,1,… → data stable during stalls, exactly 8 handshakes, no duplicates or skips.
- Two frames captured on consecutive cycles with out_ready=0 → in_ready=0 after the second. A third fft_valid sets overrun=1 and drop_cnt=1. Releasing out_ready yields 16 bins, frame A then frame B, with no bubble.
- Corner values re=0x8000, im=0x8000 → out_mag=0x10000. clr_ovf pulse → overrun=0, drop_cnt=0.
- Assert rst during bin 3 of a frame with a second frame buffered → next cycle out_valid=0 and in_ready=1. A new capture after reset emits from bin 0.

Source files
------------

// File: rtl/fantasticfft_fft8_drain.sv
// FFT8 result drain: captures whole 8-bin frames into a two-slot ping-pong
// buffer and streams them out one bin per cycle with an L1 magnitude.
module fantasticfft_fft8_drain #(
   parameter int WIDTH  = 16,
   parameter int FRAC   = 8,
   parameter int BITREV = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               fft_valid,
   input  logic [8*WIDTH-1:0] y_re,
   input  logic [8*WIDTH-1:0] y_im,
   output logic               in_ready,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   out_re,
   output logic [WIDTH-1:0]   out_im,
   output logic [WIDTH:0]     out_mag,
   output logic [2:0]         out_bin,
   output logic               out_last,
   input  logic               clr_ovf,
   output logic               overrun,
   output logic [7:0]         drop_cnt
);

   // FRAC only describes the number format; bins pass through untouched.
   if (FRAC >= WIDTH) begin : g_bad_frac
      $error("FRAC must be smaller than WIDTH");
   end

   typedef enum logic {IDLE, STREAM} state_t;

   state_t             state;
   logic [8*WIDTH-1:0] slot_re [2];
   logic [8*WIDTH-1:0] slot_im [2];
   logic               wr_ptr;
   logic               rd_ptr;
   logic [1:0]         count;
   logic [2:0]         e;

   logic               hs, last_hs, cap, drop;
   logic [2:0]         e_nxt, bin_nxt;
   logic               rd_nxt;
   logic [1:0]         cnt_nxt;
   logic [8*WIDTH-1:0] src_re, src_im;
   logic [WIDTH-1:0]   re_nxt, im_nxt;
   logic [WIDTH:0]     re_ext, im_ext, abs_re, abs_im, mag_nxt;

   assign in_ready = (count != 2'd2);

   // Next-cycle view of the stream; the presented bin is always computed for
   // the state after this edge so that outputs can be fully registered.
   always_comb begin
      hs      = out_valid && out_ready;
      last_hs = hs && (e == 3'd7);
      cap     = fft_valid && (count != 2'd2);
      drop    = fft_valid && (count == 2'd2);
      e_nxt   = hs ? e + 3'd1 : e;
      rd_nxt  = last_hs ? ~rd_ptr : rd_ptr;
      cnt_nxt = count + {1'b0, cap} - {1'b0, last_hs};
      bin_nxt = (BITREV != 0) ? {e_nxt[0], e_nxt[1], e_nxt[2]} : e_nxt;
      // A frame captured this edge into the slot about to be read is not in
      // the slot yet, so forward it straight from the inputs.
      if (cap && (wr_ptr == rd_nxt)) begin
         src_re = y_re;
         src_im = y_im;
      end else begin
         src_re = slot_re[rd_nxt];
         src_im = slot_im[rd_nxt];
      end
      re_nxt  = src_re[WIDTH*bin_nxt +: WIDTH];
      im_nxt  = src_im[WIDTH*bin_nxt +: WIDTH];
      re_ext  = {re_nxt[WIDTH-1], re_nxt};
      im_ext  = {im_nxt[WIDTH-1], im_nxt};
      abs_re  = re_ext[WIDTH] ? -re_ext : re_ext;
      abs_im  = im_ext[WIDTH] ? -im_ext : im_ext;
      mag_nxt = abs_re + abs_im;
   end

   // Frame storage; contents are meaningless while count says a slot is free.
   always_ff @(posedge clk) begin
      if (cap) begin
         slot_re[wr_ptr] <= y_re;
         slot_im[wr_ptr] <= y_im;
      end
   end

   // Stream FSM with pointers, occupancy, emit counter and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_re    <= '0;
         out_im    <= '0;
         out_mag   <= '0;
         out_bin   <= '0;
         out_last  <= 1'b0;
         wr_ptr    <= 1'b0;
         rd_ptr    <= 1'b0;
         count     <= 2'd0;
         e         <= 3'd0;
      end else begin
         count  <= cnt_nxt;
         e      <= e_nxt;
         rd_ptr <= rd_nxt;
         if (cap) wr_ptr <= ~wr_ptr;
         case (state)
            IDLE: begin
               if (cap) begin
                  state     <= STREAM;
                  out_valid <= 1'b1;
               end
            end
            STREAM: begin
               if (last_hs && (cnt_nxt == 2'd0)) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: begin
               state     <= IDLE;
               out_valid <= 1'b0;
            end
         endcase
         if (cnt_nxt != 2'd0) begin
            out_re   <= re_nxt;
            out_im   <= im_nxt;
            out_mag  <= mag_nxt;
            out_bin  <= bin_nxt;
            out_last <= (e_nxt == 3'd7);
         end
      end
   end

   // Sticky overrun and saturating drop counter; a drop beats a same-cycle clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun  <= 1'b0;
         drop_cnt <= 8'd0;
      end else if (drop) begin
         overrun  <= 1'b1;
         if (clr_ovf)                drop_cnt <= 8'd1;
         else if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
      end else if (clr_ovf) begin
         overrun  <= 1'b0;
         drop_cnt <= 8'd0;
      end
   end

endmodule
